// File: rtl/lc3_controller.sv
// Pipeline controller for the LC3 five-stage datapath: stage enables, data-memory
// sequencing FSM that freezes the pipeline, and execute-stage branch resolution.
module lc3_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        squash_decode,
  output logic        squash_execute,
  output logic [1:0]  mem_state
);

  localparam logic [1:0] ST_READ     = 2'd0;
  localparam logic [1:0] ST_INDIRECT = 2'd1;
  localparam logic [1:0] ST_WRITE    = 2'd2;
  localparam logic [1:0] ST_IDLE     = 2'd3;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;

  logic [1:0] state_q, state_d;
  logic       exec_new_q, exec_new_d;
  logic [3:0] opcode_s;
  logic       is_mem_s, is_jmp_s, is_ctrl_s;
  logic       mem_start_s, mem_busy_s, run_s, br_eval_s, br_taken_s;

  assign opcode_s  = IR_Exec[15:12];
  assign is_mem_s  = (opcode_s == OP_LD)  || (opcode_s == OP_LDR) || (opcode_s == OP_LDI) ||
                     (opcode_s == OP_ST)  || (opcode_s == OP_STR) || (opcode_s == OP_STI);
  assign is_jmp_s  = (opcode_s == OP_JMP);
  assign is_ctrl_s = (opcode_s == OP_BR) || is_jmp_s;

  // The completion cycle (READ/WRITE with complete_data) is deliberately not busy.
  assign mem_start_s = (state_q == ST_IDLE) && exec_new_q && is_mem_s;
  assign mem_busy_s  = mem_start_s ||
                       ((state_q != ST_IDLE) &&
                        !(((state_q == ST_READ) || (state_q == ST_WRITE)) && complete_data));
  assign run_s       = rst && !mem_busy_s && complete_instr;
  // Gated by run so a branch stalled on instruction memory is evaluated exactly once.
  assign br_eval_s   = run_s && exec_new_q && is_ctrl_s;
  assign br_taken_s  = br_eval_s && (is_jmp_s || (|(IR_Exec[11:9] & psr)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      exec_new_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exec_new_q <= exec_new_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_start_s) begin
          if ((opcode_s == OP_LDI) || (opcode_s == OP_STI)) begin
            state_d = ST_INDIRECT;
          end else if (IR_Exec[12]) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INDIRECT: begin
        if (complete_data) begin
          state_d = IR_Exec[12] ? ST_WRITE : ST_READ;
        end else begin
          state_d = ST_INDIRECT;
        end
      end
      ST_READ, ST_WRITE: begin
        if (complete_data) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exec_new_d = exec_new_q;
    if (run_s) begin
      exec_new_d = 1'b1;
    end else if (mem_start_s || br_eval_s) begin
      exec_new_d = 1'b0;
    end else begin
      exec_new_d = exec_new_q;
    end
  end

  always_comb begin
    enable_updatePC  = run_s;
    enable_fetch     = run_s;
    enable_decode    = run_s;
    enable_execute   = run_s;
    enable_writeback = run_s;
    br_taken         = br_taken_s;
    squash_decode    = br_taken_s;
    squash_execute   = br_taken_s;
    mem_state        = state_q;
  end

endmodule

// File: tb/tb_lc3_controller.sv
// Self-checking bench for lc3_controller: cycle-by-cycle vector table plus a
// hand-written mid-access reset sequence, checked through an expectation queue.
module tb_lc3_controller;

  logic        clk = 1'b0;
  logic        rst, complete_instr, complete_data;
  logic [15:0] IR_Exec;
  logic [2:0]  psr;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic        br_taken, squash_decode, squash_execute;
  logic [1:0]  mem_state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst_v;
    logic        ci;
    logic        cd;
    logic [15:0] ir;
    logic [2:0]  psr_v;
    logic        en;
    logic        br;
    logic [1:0]  ms;
  } vec_t;

  vec_t vecs[27];
  vec_t exp_q[$];

  lc3_controller dut (
    .clk(clk), .rst(rst), .complete_instr(complete_instr), .complete_data(complete_data),
    .IR_Exec(IR_Exec), .psr(psr),
    .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch), .enable_decode(enable_decode),
    .enable_execute(enable_execute), .enable_writeback(enable_writeback),
    .br_taken(br_taken), .squash_decode(squash_decode), .squash_execute(squash_execute),
    .mem_state(mem_state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic ci, input logic cd, input logic [15:0] ir,
                              input logic [2:0] p, input logic en, input logic br, input logic [1:0] ms);
    vec_t v;
    v.rst_v = r; v.ci = ci; v.cd = cd; v.ir = ir; v.psr_v = p;
    v.en = en; v.br = br; v.ms = ms;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs, queue its expectation, compare mid-cycle, advance past the edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    rst = v.rst_v; complete_instr = v.ci; complete_data = v.cd;
    IR_Exec = v.ir; psr = v.psr_v;
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    check("enables", idx,
          {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback},
          {5{e.en}});
    check("br_taken", idx, {4'b0000, br_taken}, {4'b0000, e.br});
    check("squash_decode", idx, {4'b0000, squash_decode}, {4'b0000, e.br});
    check("squash_execute", idx, {4'b0000, squash_execute}, {4'b0000, e.br});
    check("mem_state", idx, {3'b000, mem_state}, {3'b000, e.ms});
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] NOP = 16'h5020;

  initial begin
    // reset, release, LDR with 3 wait cycles
    vecs[0]  = mk(1'b0, 1'b1, 1'b0, NOP,     3'b000, 1'b0, 1'b0, 2'd3);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, NOP,     3'b000, 1'b1, 1'b0, 2'd3);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 16'h6283, 3'b000, 1'b0, 1'b0, 2'd3);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 16'h6283, 3'b000, 1'b0, 1'b0, 2'd0);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 16'h6283, 3'b000, 1'b0, 1'b0, 2'd0);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 16'h6283, 3'b000, 1'b0, 1'b0, 2'd0);
    vecs[6]  = mk(1'b1, 1'b1, 1'b1, 16'h6283, 3'b000, 1'b1, 1'b0, 2'd0);
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, NOP,     3'b000, 1'b1, 1'b0, 2'd3);
    // STI through INDIRECT then WRITE
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, 16'hB005, 3'b000, 1'b0, 1'b0, 2'd3);
    vecs[9]  = mk(1'b1, 1'b1, 1'b0, 16'hB005, 3'b000, 1'b0, 1'b0, 2'd1);
    vecs[10] = mk(1'b1, 1'b1, 1'b1, 16'hB005, 3'b000, 1'b0, 1'b0, 2'd1);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 16'hB005, 3'b000, 1'b0, 1'b0, 2'd2);
    vecs[12] = mk(1'b1, 1'b1, 1'b1, 16'hB005, 3'b000, 1'b1, 1'b0, 2'd2);
    // BRz taken, BRz not taken, BR nzp=000
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 16'h0403, 3'b010, 1'b1, 1'b1, 2'd3);
    vecs[14] = mk(1'b1, 1'b1, 1'b0, NOP,     3'b010, 1'b1, 1'b0, 2'd3);
    vecs[15] = mk(1'b1, 1'b1, 1'b0, 16'h0403, 3'b100, 1'b1, 1'b0, 2'd3);
    vecs[16] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 3'b111, 1'b1, 1'b0, 2'd3);
    // JMP deferred by two instruction-memory stalls
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 16'hC1C0, 3'b000, 1'b0, 1'b0, 2'd3);
    vecs[18] = mk(1'b1, 1'b0, 1'b0, 16'hC1C0, 3'b000, 1'b0, 1'b0, 2'd3);
    vecs[19] = mk(1'b1, 1'b1, 1'b0, 16'hC1C0, 3'b000, 1'b1, 1'b1, 2'd3);
    vecs[20] = mk(1'b1, 1'b1, 1'b0, NOP,     3'b000, 1'b1, 1'b0, 2'd3);
    // back-to-back LDs; second start sees complete_data already high
    vecs[21] = mk(1'b1, 1'b1, 1'b0, 16'h2001, 3'b000, 1'b0, 1'b0, 2'd3);
    vecs[22] = mk(1'b1, 1'b1, 1'b0, 16'h2001, 3'b000, 1'b0, 1'b0, 2'd0);
    vecs[23] = mk(1'b1, 1'b1, 1'b1, 16'h2001, 3'b000, 1'b1, 1'b0, 2'd0);
    vecs[24] = mk(1'b1, 1'b1, 1'b1, 16'h2202, 3'b000, 1'b0, 1'b0, 2'd3);
    vecs[25] = mk(1'b1, 1'b1, 1'b1, 16'h2202, 3'b000, 1'b1, 1'b0, 2'd0);
    vecs[26] = mk(1'b1, 1'b1, 1'b0, NOP,     3'b000, 1'b1, 1'b0, 2'd3);

    rst = 1'b0; complete_instr = 1'b1; complete_data = 1'b0; IR_Exec = NOP; psr = 3'b000;
    @(posedge clk);
    #1;
    for (int i = 0; i < 27; i++) begin
      apply(vecs[i], i);
    end

    // Reset asserted mid-READ aborts at once; release then runs normally.
    apply(mk(1'b1, 1'b1, 1'b0, 16'h6283, 3'b000, 1'b0, 1'b0, 2'd3), 100);
    apply(mk(1'b1, 1'b1, 1'b0, 16'h6283, 3'b000, 1'b0, 1'b0, 2'd0), 101);
    apply(mk(1'b0, 1'b1, 1'b1, 16'h6283, 3'b000, 1'b0, 1'b0, 2'd3), 102);
    apply(mk(1'b0, 1'b1, 1'b1, 16'h0E03, 3'b111, 1'b0, 1'b0, 2'd3), 103);
    apply(mk(1'b1, 1'b1, 1'b0, NOP,      3'b000, 1'b1, 1'b0, 2'd3), 104);
    apply(mk(1'b1, 1'b1, 1'b0, 16'h0E03, 3'b001, 1'b1, 1'b1, 2'd3), 105);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
